// File: rtl/add_seq32.sv
// 32-bit add/subtract sequenced over two passes of an external 16-bit adder.
// Result and flags commit together after the high pass.
module add_seq32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        cf_in,
  output logic [15:0] adder_a,
  output logic [15:0] adder_b,
  output logic        adder_c0,
  input  logic [15:0] adder_sum,
  input  logic        adder_cf,
  input  logic        adder_of,
  input  logic        adder_zf,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        sf,
  output logic        cf,
  output logic        of,
  output logic        pf,
  output logic        zf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI
  } state_t;

  state_t      r_state;
  logic [31:0] r_opa;
  logic [31:0] r_b;
  logic        r_c0;
  logic        r_sub;
  logic [15:0] r_lo_sum;
  logic        r_lo_cf;
  logic        r_lo_zf;
  logic [31:0] r_result;
  logic        r_sf;
  logic        r_cf;
  logic        r_of;
  logic        r_pf;
  logic        r_zf;
  logic        r_busy;
  logic        r_done;
  logic        w_c0;

  // Subtraction is a + ~b + 1; borrow-in turns the +1 into +~cf_in.
  always_comb begin
    w_c0 = 1'b0;
    unique case (op)
      2'b00: w_c0 = 1'b0;
      2'b01: w_c0 = cf_in;
      2'b10: w_c0 = 1'b1;
      2'b11: w_c0 = ~cf_in;
      default: w_c0 = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_opa    <= '0;
      r_b      <= '0;
      r_c0     <= 1'b0;
      r_sub    <= 1'b0;
      r_lo_sum <= '0;
      r_lo_cf  <= 1'b0;
      r_lo_zf  <= 1'b0;
      r_result <= '0;
      r_sf     <= 1'b0;
      r_cf     <= 1'b0;
      r_of     <= 1'b0;
      r_pf     <= 1'b0;
      r_zf     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opa   <= opa;
            r_b     <= op[1] ? ~opb : opb;
            r_c0    <= w_c0;
            r_sub   <= op[1];
            r_busy  <= 1'b1;
            r_state <= S_LO;
          end
        end
        S_LO: begin
          r_lo_sum <= adder_sum;
          r_lo_cf  <= adder_cf;
          r_lo_zf  <= adder_zf;
          r_state  <= S_HI;
        end
        S_HI: begin
          r_result <= {adder_sum, r_lo_sum};
          r_sf     <= adder_sum[15];
          r_cf     <= adder_cf ^ r_sub;
          r_of     <= adder_of;
          r_zf     <= r_lo_zf & adder_zf;
          r_pf     <= ~^r_lo_sum[7:0];
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    adder_a  = '0;
    adder_b  = '0;
    adder_c0 = 1'b0;
    unique case (r_state)
      S_LO: begin
        adder_a  = r_opa[15:0];
        adder_b  = r_b[15:0];
        adder_c0 = r_c0;
      end
      S_HI: begin
        adder_a  = r_opa[31:16];
        adder_b  = r_b[31:16];
        adder_c0 = r_lo_cf;
      end
      default: begin
        adder_a  = '0;
        adder_b  = '0;
        adder_c0 = 1'b0;
      end
    endcase
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign sf     = r_sf;
  assign cf     = r_cf;
  assign of     = r_of;
  assign pf     = r_pf;
  assign zf     = r_zf;

endmodule

// File: tb/tb_add_seq32.sv
// Directed bench for add_seq32 with a behavioural 16-bit adder attached.
// Vectors carry hand-computed results and {sf,cf,of,pf,zf} flags.
module tb_add_seq32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        cf_in;
  logic [15:0] adder_a;
  logic [15:0] adder_b;
  logic        adder_c0;
  logic [15:0] adder_sum;
  logic        adder_cf;
  logic        adder_of;
  logic        adder_zf;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        sf, cf, of, pf, zf;
  logic [16:0] w_full;

  int n_chk;
  int n_fail;

  add_seq32 dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .opa(opa), .opb(opb), .cf_in(cf_in),
    .adder_a(adder_a), .adder_b(adder_b), .adder_c0(adder_c0),
    .adder_sum(adder_sum), .adder_cf(adder_cf),
    .adder_of(adder_of), .adder_zf(adder_zf),
    .busy(busy), .done(done), .result(result),
    .sf(sf), .cf(cf), .of(of), .pf(pf), .zf(zf)
  );

  // external 16-bit adder
  assign w_full    = {1'b0, adder_a} + {1'b0, adder_b} + {16'd0, adder_c0};
  assign adder_sum = w_full[15:0];
  assign adder_cf  = w_full[16];
  assign adder_of  = (adder_a[15] == adder_b[15]) &&
                     (w_full[15] != adder_a[15]);
  assign adder_zf  = (w_full[15:0] == 16'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] flg();
    return {27'd0, sf, cf, of, pf, zf};
  endfunction

  // b2b=1: caller is already at the negedge where start must be driven.
  task automatic run(input vec_t v, input bit b2b);
    logic [31:0] prev;
    if (!b2b) @(negedge clk);
    op = v.op; opa = v.a; opb = v.b; cf_in = v.ci; start = 1'b1;
    prev = result;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({v.name, " LO busy"}, {31'd0, busy}, 32'd1);
    chk({v.name, " LO done"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    chk({v.name, " HI result held"}, result, prev);
    chk({v.name, " HI done"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    chk({v.name, " done"}, {31'd0, done}, 32'd1);
    chk({v.name, " busy"}, {31'd0, busy}, 32'd0);
    chk({v.name, " result"}, result, v.res);
    chk({v.name, " flags"}, flg(), {27'd0, v.fl});
  endtask

  vec_t vt[9];

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00;
    opa = '0; opb = '0; cf_in = 1'b0;

    //            name        op     a             b             ci    res           {sf,cf,of,pf,zf}
    vt[0] = '{"add_ffff",  2'b00, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 5'b00010};
    vt[1] = '{"sub_0m1",   2'b10, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 5'b11010};
    vt[2] = '{"add_ovf",   2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 5'b10110};
    vt[3] = '{"adc_wrap",  2'b01, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 5'b01011};
    vt[4] = '{"sbb_ci1",   2'b11, 32'h00000005, 32'h00000003, 1'b1, 32'h00000001, 5'b00000};
    vt[5] = '{"sbb_ci0",   2'b11, 32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 5'b00000};
    vt[6] = '{"sub_eq",    2'b10, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 5'b00011};
    vt[7] = '{"add_mix",   2'b00, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 5'b00000};
    vt[8] = '{"sbb_ovf",   2'b11, 32'h80000000, 32'h00000000, 1'b1, 32'h7FFFFFFF, 5'b00110};

    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset flags", flg(), 32'd0);
    chk("reset adder_a", {16'd0, adder_a}, 32'd0);
    repeat (2) @(negedge clk);
    chk("reset held adder_c0", {31'd0, adder_c0}, 32'd0);

    // Start presented in the same cycle reset drops.
    rst = 1'b0;
    run(vt[0], 1'b1);
    for (int i = 1; i < 9; i++) run(vt[i], (i % 2) == 1);

    // adder_c0 during HI carries the low-pass carry out.
    @(negedge clk);
    op = 2'b00; opa = 32'h0000FFFF; opb = 32'h1; cf_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("LO adder_a", {16'd0, adder_a}, 32'h0000FFFF);
    @(negedge clk);
    chk("HI adder_c0", {31'd0, adder_c0}, 32'd1);
    chk("HI adder_a", {16'd0, adder_a}, 32'd0);
    @(negedge clk);
    chk("carry seq result", result, 32'h00010000);

    // Start held with new operands while busy is ignored.
    @(negedge clk);
    op = 2'b00; opa = 32'd1; opb = 32'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = 2'b10; opa = 32'd100; opb = 32'd200;
    @(negedge clk);
    chk("hold HI busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("hold done", {31'd0, done}, 32'd1);
    chk("hold result", result, 32'd3);
    @(negedge clk);
    chk("hold no second done", {31'd0, done}, 32'd0);
    chk("hold idle", {31'd0, busy}, 32'd0);

    // Make flags nonzero, then reset during HI.
    run(vt[1], 1'b0);
    @(negedge clk);
    op = 2'b00; opa = 32'h11111111; opb = 32'h22222222; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstHI busy", {31'd0, busy}, 32'd0);
    chk("rstHI done", {31'd0, done}, 32'd0);
    chk("rstHI result", result, 32'd0);
    chk("rstHI flags", flg(), 32'd0);
    chk("rstHI adder_b", {16'd0, adder_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstHI no done", {31'd0, done}, 32'd0);
      chk("rstHI result stays", result, 32'd0);
    end
    run(vt[7], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
